mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store bus master downstream of the multi-cycle control unit. During MEM_S4 it takes
//  the bus_rden/bus_wren request, the ALU address, rs2 data and funct3. It drives a
//  req/ack word bus with byte enables, sign/zero-extends load data and stalls the FSM
//  until the access completes or faults.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max REQ cycles without bus_ack before abort (1..65535)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, synchronous, active-high
//  req_rden    in   1   load request (level; control unit bus_rden)
//  req_wren    in   1   store request (level; control unit bus_wren)
//  funct3      in   3   RV32I width/sign field of the load/store
//  addr        in   32  byte address from ALU
//  wdata       in   32  store data (rs2, right-aligned)
//  stall       out  1   hold control unit FSM in MEM_S4
//  done        out  1   1-cycle completion strobe (ok or fault)
//  err         out  1   fault flag, valid with done
//  rdata_ext   out  32  extended load result, held until next accepted access
//  bus_req     out  1   bus request
//  bus_we      out  1   1 = write
//  bus_addr    out  32  word address {addr[31:2],2'b00}
//  bus_be      out  4   byte enables
//  bus_wdata   out  32  lane-aligned write data
//  bus_ack     in   1   bus completion; read data valid same cycle
//  bus_rdata   in   32  read word
// BEHAVIOUR
//  Reset: state IDLE; every output and internal register is 0; timeout counter is 0.
//  Sync rst has priority in every state. Mid-access rst drops bus_req on the next edge.
//  FSM states: IDLE, REQ, DONE, FAULT.
//   IDLE: if req_wren|req_rden, latch addr/funct3/wdata/dir (wren wins if both set).
//         If the access is legal, go to REQ; otherwise go to FAULT. stall=1 in the accept cycle.
//   REQ: bus_req=1 with bus_we/bus_addr/bus_be/bus_wdata stable from the latched values.
//        stall=1. On bus_ack: capture rdata_ext (loads only), then go to DONE.
//        The counter increments each REQ cycle without ack. When the count equals
//        TIMEOUT_CYCLES-1 with no ack, bus_req drops and the state goes to FAULT.
//   DONE: done=1, err=0, stall=0, bus_req=0. Next state is IDLE unconditionally.
//         Requests are ignored here because the requester leaves MEM_S4 in this cycle.
//   FAULT: done=1, err=1, stall=0, no bus activity, rdata_ext unchanged. Next state is IDLE.
//  Latency: accept cycle plus N wait cycles (ack in the Nth REQ cycle, N>=1) plus DONE.
//   The minimum is 3 cycles from request seen to done.
//  Legality:
//   funct3 in {000,001,010} for loads and stores, plus {100,101} for loads only.
//   Half accesses require addr[0]=0. Word accesses require addr[1:0]=0.
//   Anything else is a misalignment or illegal-width fault.
//  Byte enables (o = addr[1:0]):
//   B: 4'b0001<<o, wdata lanes = {4{wdata[7:0]}}.
//   H: o[1] ? 1100 : 0011, wdata lanes = {2{wdata[15:0]}}.
//   W: 1111, wdata passes through.
//  Load extract:
//   byte = bus_rdata[8*o +: 8]; half = bus_rdata[16*o[1] +: 16].
//   LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
//  Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to REQ.
//  A late bus_ack arriving in DONE/FAULT/IDLE is ignored.
//  bus_ack in the same cycle as the timeout compare wins (the access completes normally).
// TESTING
//  LW addr=0x100, ack 1st REQ cycle, rdata=0xDEADBEEF -> be=1111, done at cycle 3,
//   rdata_ext=0xDEADBEEF, err=0.
//  LB addr=0x103, rdata=0x80112233 -> be=1000, rdata_ext=0xFFFFFF80.
//   LBU at the same address -> rdata_ext=0x00000080.
//  SH addr=0x202, wdata=0x0000ABCD, ack after 4 waits -> bus_be=1100, bus_wdata=0xABCDABCD,
//   bus_we=1, stall for 5 cycles.
//  SW addr=0x101 -> FAULT: no bus_req, done=1, err=1 one cycle after accept.
//   Load funct3=011 also faults.
//  TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, then done=1 and err=1.
//   An ack arriving afterwards is ignored.
//  rst asserted during REQ wait -> next cycle bus_req=0, stall=0, state IDLE,
//   rdata_ext=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store bus master for the multi-cycle core: turns a MEM-stage request into a
// req/ack word-bus transaction with byte enables, extends load data, and stalls until done.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rden,
    input  logic        req_wren,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata_ext,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]    state;
    logic [31:0]   addr_q;
    logic [2:0]    f3_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;

    logic          legal;
    logic [1:0]    ofs;
    logic [3:0]    be_c;
    logic [31:0]   wlane_c;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext_c;

    // Legality is judged on the live inputs so the accept cycle decides REQ vs FAULT.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~req_wren;
            3'b101:  legal = ~req_wren & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    assign ofs = addr_q[1:0];

    always_comb begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ofs;
                wlane_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_c    = ofs[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wlane_c = wdata_q;
            end
        endcase
    end

    assign byte_v = bus_rdata[{ofs, 3'b000} +: 8];
    assign half_v = bus_rdata[{ofs[1], 4'b0000} +: 16];

    always_comb begin
        ext_c = bus_rdata;
        case (f3_q)
            3'b000:  ext_c = {{24{byte_v[7]}}, byte_v};
            3'b001:  ext_c = {{16{half_v[15]}}, half_v};
            3'b100:  ext_c = {24'd0, byte_v};
            3'b101:  ext_c = {16'd0, half_v};
            default: ext_c = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_wren | req_rden) begin
                        addr_q  <= addr;
                        f3_q    <= funct3;
                        wdata_q <= wdata;
                        we_q    <= req_wren;
                        cnt     <= '0;
                        state   <= legal ? S_REQ : S_FAULT;
                    end
                end
                S_REQ: begin
                    // An ack coinciding with the final count still completes normally.
                    if (bus_ack) begin
                        if (!we_q) rdata_q <= ext_c;
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall     = ((state == S_IDLE) & (req_rden | req_wren)) | (state == S_REQ);
    assign done      = (state == S_DONE) | (state == S_FAULT);
    assign err       = (state == S_FAULT);
    assign rdata_ext = rdata_q;
    assign bus_req   = (state == S_REQ);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be_c : 4'd0;
    assign bus_wdata = bus_req ? wlane_c : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random load/store traffic against mem_access_unit, checked by a
// byte-level reference model of the bus and load extension rules.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rden, req_wren;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata_ext;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata = 32'd0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req_rden(req_rden), .req_wren(req_wren),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .err(err), .rdata_ext(rdata_ext), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input bit is_wr, input logic [2:0] f3, input logic [31:0] a);
        bit ok_width;
        ok_width = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                   (!is_wr && (f3 == 3'd4 || f3 == 3'd5));
        return ok_width && ((a % access_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int o, n;
        logic [3:0] m;
        o = int'(a % 4);
        n = access_size(f3);
        m = 4'd0;
        for (int i = 0; i < n; i++) m[o + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (access_size(f3))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
        logic [31:0] v;
        int n;
        n = access_size(f3);
        if (n == 4) return rw;
        v = (rw >> (8 * (a % 4))) & ((n == 1) ? 32'hFF : 32'hFFFF);
        if (f3[2] == 1'b0 && v[8*n-1]) v = v | ((n == 1) ? 32'hFFFFFF00 : 32'hFFFF0000);
        return v;
    endfunction

    // ack_at: REQ cycle (1-based) in which the bus answers; > TMO means never.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rw);
        bit legal, acked;
        @(negedge clk);
        req_rden = rd; req_wren = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        #1;
        chk("accept_stall", {31'd0, stall}, 32'd1);
        chk("accept_req", {31'd0, bus_req}, 32'd0);
        legal = model_legal(wr, f3, a);
        acked = 1'b0;
        if (legal) begin
            for (int k = 1; k <= TMO; k++) begin
                @(negedge clk);
                bus_ack = 1'b0;
                chk("req_bus_req", {31'd0, bus_req}, 32'd1);
                chk("req_stall", {31'd0, stall}, 32'd1);
                chk("req_done", {31'd0, done}, 32'd0);
                chk("req_we", {31'd0, bus_we}, {31'd0, wr});
                chk("req_addr", bus_addr, a & 32'hFFFFFFFC);
                chk("req_be", {28'd0, bus_be}, {28'd0, model_be(f3, a)});
                if (wr) chk("req_wdata", bus_wdata, model_lanes(f3, wd));
                if (k == ack_at) begin
                    bus_ack = 1'b1; bus_rdata = rw; acked = 1'b1;
                    break;
                end
                bus_rdata = $urandom;
            end
        end
        if (acked && !wr) exp_rdata = model_ext(f3, a, rw);
        @(negedge clk);
        // A stray ack in the completion cycle must be ignored.
        bus_ack = !acked;
        bus_rdata = $urandom;
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_err", {31'd0, err}, {31'd0, !acked});
        chk("fin_stall", {31'd0, stall}, 32'd0);
        chk("fin_bus_req", {31'd0, bus_req}, 32'd0);
        chk("fin_rdata", rdata_ext, exp_rdata);
        req_rden = 1'b0; req_wren = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_bus_req", {31'd0, bus_req}, 32'd0);
        chk("idle_rdata", rdata_ext, exp_rdata);
    endtask

    initial begin
        rst = 1'b1; req_rden = 1'b0; req_wren = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_rdata", rdata_ext, 32'd0);
        rst = 1'b0;

        access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        chk("lw_const", rdata_ext, 32'hDEADBEEF);
        access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lb_const", rdata_ext, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80112233);
        chk("lbu_const", rdata_ext, 32'h00000080);
        access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 4, 32'h0);
        access(0, 1, 3'b010, 32'h101, 32'h12345678, 1, 32'h0);
        access(1, 0, 3'b011, 32'h104, 32'h0, 1, 32'h0);
        access(1, 0, 3'b101, 32'h106, 32'h0, 3, 32'h9ABC8001);
        access(1, 0, 3'b010, 32'h400, 32'h0, TMO + 1, 32'h0);
        access(1, 1, 3'b100, 32'h500, 32'h55, 1, 32'h0);

        // Reset while the bus is still waiting for an ack.
        @(negedge clk);
        req_rden = 1'b1; funct3 = 3'b010; addr = 32'h300;
        repeat (2) @(negedge clk);
        chk("mid_bus_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1; req_rden = 1'b0;
        @(negedge clk);
        exp_rdata = 32'd0;
        chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_rdata", rdata_ext, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 60; i++) begin
            bit rd, wr;
            rd = 1'($urandom % 2);
            wr = rd ? 1'($urandom % 2) : 1'b1;
            access(rd, wr, 3'($urandom % 8), $urandom, $urandom,
                   int'($urandom_range(1, TMO + 1)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
